// File: rtl/efp_to_decimal.sv
`default_nettype none
// ============================================================================
// Module   : efp_to_decimal
// Brief    : Decodes an EFP8 code (sign + 7-bit log2 index) into a 32-bit
//            signed BCD word (sign nibble + 7 digits, 4 fractional) through a
//            registered ROM read. Optional macro EFP_NEG_ZERO_EN keeps the sign
//            nibble on code 0x80 (negative zero).
// Revision : 1.0 - initial release
// ============================================================================
module efp_to_decimal #(
    parameter logic [3:0] SIGN_NIBBLE = 4'h1,
    parameter int         TABLE_DEPTH = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    input  logic [7:0]  efp_input,
    output logic [31:0] decimal_output,
    output logic        busy,
    output logic        done
);

    // Entry k holds 2^((k-56)/8) rounded to 4 fractional decimal digits, as
    // BCD. Mantissas of 2^(f/8) are scaled by 1e9, so the x1e4 result needs a
    // further divide by 1e5 folded together with the power-of-two shift.
    function automatic logic [27:0] rom_entry(input int k);
        logic [63:0] mant;
        logic [63:0] num;
        logic [63:0] den;
        logic [63:0] q;
        logic [27:0] bcd;
        int          sh;
        int          e;
        int          f;
        sh = k - 56;
        e  = sh >>> 3;
        f  = sh & 7;
        case (f)
            0:       mant = 64'd1000000000;
            1:       mant = 64'd1090507733;
            2:       mant = 64'd1189207115;
            3:       mant = 64'd1296839555;
            4:       mant = 64'd1414213562;
            5:       mant = 64'd1542210825;
            6:       mant = 64'd1681792831;
            default: mant = 64'd1834008086;
        endcase
        if (e >= 0) begin
            num = mant << e;
            den = 64'd100000;
        end else begin
            num = mant;
            den = 64'd100000 << (-e);
        end
        q = (num + (den >> 1)) / den;
        bcd = '0;
        for (int i = 0; i < 7; i++) begin
            bcd[i*4 +: 4] = 4'(q % 64'd10);
            q = q / 64'd10;
        end
        return bcd;
    endfunction

    logic [27:0] rom [TABLE_DEPTH];

    for (genvar k = 0; k < TABLE_DEPTH; k++) begin : g_rom
        localparam logic [27:0] ENTRY = rom_entry(k);
        assign rom[k] = ENTRY;
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        FORMAT = 2'd2
    } state_t;

    state_t      state;
    logic        button_q;
    logic [7:0]  code_r;
    logic [27:0] rom_q;

    logic        w_start;
    logic [27:0] w_mag;
    logic        w_neg;

    assign w_start = button & ~button_q;
    assign w_mag   = (code_r[6:0] == 7'd0) ? 28'd0 : rom_q;

`ifdef EFP_NEG_ZERO_EN
    assign w_neg = code_r[7];
`else
    assign w_neg = code_r[7] && (w_mag != 28'd0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            button_q       <= 1'b1;   // a button held through reset is not an edge
            code_r         <= 8'd0;
            rom_q          <= 28'd0;
            decimal_output <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            button_q <= button;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (w_start) begin
                        code_r <= efp_input;
                        busy   <= 1'b1;
                        state  <= READ;
                    end
                end
                READ: begin
                    rom_q <= rom[code_r[6:0]];
                    state <= FORMAT;
                end
                FORMAT: begin
                    decimal_output <= {(w_neg ? SIGN_NIBBLE : 4'h0), w_mag};
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_efp_to_decimal.sv
`default_nettype none
// ============================================================================
// Module   : tb_efp_to_decimal
// Brief    : Directed self-checking bench for efp_to_decimal.
// Revision : 1.0 - initial release
// ============================================================================
module tb_efp_to_decimal;

    logic        clk;
    logic        rst;
    logic        button;
    logic [7:0]  efp_input;
    logic [31:0] decimal_output;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    efp_to_decimal dut (
        .clk            (clk),
        .rst            (rst),
        .button         (button),
        .efp_input      (efp_input),
        .decimal_output (decimal_output),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects button low for at least one prior edge; leaves button low.
    task automatic convert(input string tag, input logic [7:0] code, input logic [31:0] exp);
        efp_input = code;
        button    = 1'b1;
        tick();                          // E0
        check({tag, " busy@E0+1"}, {31'd0, busy}, 32'd1);
        efp_input = ~code;               // late changes must not leak in
        button    = 1'b0;
        tick();                          // E0+1
        check({tag, " busy@E0+2"}, {31'd0, busy}, 32'd1);
        check({tag, " done@E0+2"}, {31'd0, done}, 32'd0);
        tick();                          // E0+2
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " value"}, decimal_output, exp);
        check({tag, " busy_clr"}, {31'd0, busy}, 32'd0);
        tick();                          // E0+3
        check({tag, " done_drop"}, {31'd0, done}, 32'd0);
        check({tag, " hold"}, decimal_output, exp);
    endtask

    initial begin
        logic [31:0] neg_zero_exp;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        button    = 1'b1;
        efp_input = 8'h38;

        // Reset with button held high: release must not start a conversion.
        tick();
        tick();
        rst = 1'b0;
        check("reset dout", decimal_output, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("held button done", {31'd0, done}, 32'd0);
            check("held button busy", {31'd0, busy}, 32'd0);
        end
        check("held button dout", decimal_output, 32'd0);
        button = 1'b0;
        tick();

        convert("pos 0x38", 8'h38, 32'h0001_0000);
        convert("neg 0xB0", 8'hB0, 32'h1000_5000);
        convert("max 0x7F", 8'h7F, 32'h0469_5061);
        convert("min 0x01", 8'h01, 32'h0000_0085);
        convert("zero 0x00", 8'h00, 32'h0000_0000);
`ifdef EFP_NEG_ZERO_EN
        neg_zero_exp = 32'h1000_0000;
`else
        neg_zero_exp = 32'h0000_0000;
`endif
        convert("negzero 0x80", 8'h80, neg_zero_exp);
        convert("neg 0xC0", 8'hC0, 32'h1002_0000);

        // Busy blocking: a second rising edge while busy is dropped, not queued.
        efp_input = 8'h40;
        button    = 1'b1;
        tick();                          // E0 start
        button    = 1'b0;
        efp_input = 8'h48;
        tick();                          // E0+1, button_q clears
        button = 1'b1;                   // rising edge seen at E0+2 while busy
        tick();                          // E0+2
        check("block done", {31'd0, done}, 32'd1);
        check("block value", decimal_output, 32'h0002_0000);
        button = 1'b0;
        tick();                          // E0+3
        check("block no queue busy", {31'd0, busy}, 32'd0);
        check("block done drop", {31'd0, done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("block no second done", {31'd0, done}, 32'd0);
        end
        convert("after block 0x48", 8'h48, 32'h0004_0000);

        // Earliest back-to-back acceptance at E0+3.
        efp_input = 8'h40;
        button    = 1'b1;
        tick();                          // E0
        button = 1'b0;
        tick();                          // E0+1
        efp_input = 8'h48;
        button    = 1'b1;
        tick();                          // E0+2 (edge ignored? no: button_q=0, but busy)
        check("b2b first value", decimal_output, 32'h0002_0000);
        check("b2b first done", {31'd0, done}, 32'd1);
        tick();                          // E0+3: button_q=1 now, so no start here
        check("b2b ignored edge busy", {31'd0, busy}, 32'd0);
        button = 1'b0;
        tick();
        convert("b2b 0x48", 8'h48, 32'h0004_0000);
        efp_input = 8'h38;
        button    = 1'b1;
        tick();                          // E0
        button = 1'b0;
        tick();                          // E0+1
        tick();                          // E0+2
        check("e3 first value", decimal_output, 32'h0001_0000);
        button = 1'b1;
        efp_input = 8'hB0;
        tick();                          // E0+3: new edge accepted
        check("e3 accept busy", {31'd0, busy}, 32'd1);
        button = 1'b0;
        tick();
        tick();
        check("e3 second done", {31'd0, done}, 32'd1);
        check("e3 second value", decimal_output, 32'h1000_5000);
        tick();

        // Mid-conversion reset aborts with no done pulse.
        efp_input = 8'h40;
        button    = 1'b1;
        tick();                          // E0
        button = 1'b0;
        rst    = 1'b1;
        tick();                          // E0+1 reset sampled
        rst = 1'b0;
        check("abort dout", decimal_output, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort no done", {31'd0, done}, 32'd0);
        end
        check("abort dout hold", decimal_output, 32'd0);
        convert("post abort 0x38", 8'h38, 32'h0001_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/efp_to_decimal.md
Name: efp_to_decimal

Overview:
- Downstream companion of the decimal-to-EFP encoder. Decodes an 8-bit EFP code back into the team's 32-bit signed BCD decimal word for display and readback.
- EFP8 format: bit 7 is the sign; bits 6:0 are magnitude index k, where value ≈ 2^((k-56)/8).
- Decimal word: 4-bit sign nibble [31:28], then 7 BCD digits with 4 fractional digits. Example: 0x00010000 = 1.0000.
- Conversion is started by a rising edge on button, runs through a small FSM with a registered ROM read, and completes with a one-cycle done pulse.

Parameters:
- SIGN_NIBBLE, 4'h1, value placed in decimal_output[31:28] for negative results (matches the encoder's negative flag in bit 28).
- TABLE_DEPTH, 128, number of ROM entries. Fixed; any other value is unsupported.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- button  input  1  start request, level input; only its rising edge starts a conversion
- efp_input  input  8  EFP8 code; sampled on the start edge only
- decimal_output  output  32  decoded BCD word; holds its value until the next completion
- busy  output  1  high while a conversion is in flight
- done  output  1  one-cycle pulse when decimal_output has just been updated

Behaviour:
- Reset (rst=1 at a clk edge), all registers forced as follows:
  - decimal_output=0, busy=0, done=0, state=IDLE.
  - Internal button history register = 1, so a button held high through reset release does not trigger a conversion.
- Edge detect: start = button & ~button_q, where button_q is button registered each clk.
- FSM states: IDLE, READ, FORMAT.
  - IDLE: on start, latch efp_input into code_r, set busy=1, go to READ. Otherwise stay in IDLE with busy=0.
  - READ: ROM registered read of entry code_r[6:0] into rom_q; go to FORMAT.
  - FORMAT:
    - Magnitude is zero if code_r[6:0]==0, otherwise rom_q[27:0].
    - decimal_output[27:0] <= magnitude.
    - decimal_output[31:28] <= SIGN_NIBBLE if code_r[7]==1 and magnitude nonzero, else 4'h0.
    - done<=1, busy<=0, go to IDLE.
- Latency: call the start edge E0. decimal_output is valid and done=1 after edge E0+2. done drops after E0+3.
- Back-to-back operation: a new start is accepted at E0+3 at the earliest (one conversion every 3 cycles).
- ROM contents: entry k is the lower-bound BCD value of bucket k, using the same table the encoder uses. Required spot values:
  - k=1 → 0x00000085
  - k=48 → 0x00005000
  - k=56 → 0x00010000
  - k=64 → 0x00020000
  - k=127 → 0x04695061
  - Entry 0 is unused; index 0 always decodes to zero.
- Rising edges of button while busy=1 are ignored and are not queued.
- efp_input changes after the start edge do not affect the conversion in flight.
- rst asserted mid-conversion: abort immediately. No done pulse; outputs return to reset values.
- decimal_output always contains valid BCD digits (0–9 per nibble) in [27:0].

Optional Feature:
- Macro: EFP_NEG_ZERO_EN.
- Defined: code 0x80 decodes to 0x10000000 (negative zero preserved). The sign rule becomes code_r[7] alone, independent of magnitude.
- Undefined: code 0x80 decodes to 0x00000000; the sign nibble is suppressed whenever the magnitude is zero.

Test Plan:
- Reset: rst=1 with button held high → after release, no done pulse while button stays high; decimal_output=0, busy=0.
- Positive decode: efp_input=0x38, button 0→1 at E0 → busy=1 at E0+1 and E0+2; decimal_output=0x00010000 and done=1 for exactly one cycle after E0+2.
- Negative and extremes, one conversion each:
  - 0xB0 → 0x10005000
  - 0x7F → 0x04695061
  - 0x01 → 0x00000085
  - 0x00 → 0x00000000
- Negative zero: efp_input=0x80 → 0x00000000 without EFP_NEG_ZERO_EN; 0x10000000 with it.
- Busy blocking: start 0x40; toggle button and change efp_input to 0x48 during READ → single done with 0x00020000 only. A new edge at E0+3 then converts 0x48 → 0x00040000.
- Mid-operation reset: start 0x40; assert rst at E0+1 → no done pulse, decimal_output stays 0, state returns to IDLE.
